// File: rtl/mod_n_updown_counter.sv
// Modulo-N up/down counter with enable, range-checked parallel load, terminal-count
// pulse and load-error pulse. Define MOD_N_CNT_SAT_EN for saturating (non-wrapping) counts.
module mod_n_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 12,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             tc,
  output logic             load_err
);

  if (MODULUS < 2) begin : g_chk_mod_min
    $error("mod_n_updown_counter: MODULUS must be >= 2");
  end
  if (MODULUS > (2 ** WIDTH)) begin : g_chk_mod_max
    $error("mod_n_updown_counter: MODULUS must be <= 2**WIDTH");
  end
  if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_chk_rst_val
    $error("mod_n_updown_counter: RESET_VAL must be in 0..MODULUS-1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  // One extra bit so MODULUS == 2**WIDTH is representable in the load range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

`ifdef MOD_N_CNT_SAT_EN
  localparam bit SATURATE = 1'b1;
`else
  localparam bit SATURATE = 1'b0;
`endif

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  logic [WIDTH-1:0] data_d, data_q;
  logic             tc_d, tc_q;
  logic             load_err_d, load_err_q;
  logic             valid_load;
  logic             at_max;
  logic             at_zero;
  op_e              op;

  assign valid_load = load && ({1'b0, data_in} < MOD_EXT);
  assign at_max     = (data_q == MAX_VAL);
  assign at_zero    = (data_q == '0);

  always_comb begin
    if (valid_load)   op = OP_LOAD;
    else if (!en)     op = OP_HOLD;
    else if (up_down) op = OP_UP;
    else              op = OP_DOWN;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    data_d     = data_q;
    tc_d       = 1'b0;
    load_err_d = load && !valid_load;
    unique case (op)
      OP_LOAD: data_d = data_in;
      OP_UP: begin
        if (at_max) begin
          tc_d   = 1'b1;
          data_d = SATURATE ? data_q : '0;
        end else begin
          data_d = data_q + WIDTH'(1);
        end
      end
      OP_DOWN: begin
        if (at_zero) begin
          tc_d   = 1'b1;
          data_d = SATURATE ? data_q : MAX_VAL;
        end else begin
          data_d = data_q - WIDTH'(1);
        end
      end
      default: data_d = data_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= RST_VAL;
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign data_out = data_q;
  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule
